// File: rtl/truth_table_recorder.sv
// Truth-table recorder: sweeps every input vector of a combinational function,
// records implementation A's response into an internal table, counts A/B
// disagreements, then streams the table out over a valid/ready port in address
// order (entry k = response to input vector k).
module truth_table_recorder #(
  parameter int unsigned N_IN   = 8,
  parameter int unsigned N_OUT  = 5,
  parameter int unsigned SETTLE = 2   // legal range 1..15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [N_IN-1:0]    dut_x,
  input  logic [0:N_OUT-1]   dut_y_a,
  input  logic [0:N_OUT-1]   dut_y_b,
  output logic               busy,
  output logic               done,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [N_IN-1:0]    rd_addr,
  output logic [0:N_OUT-1]   rd_data,
  output logic [N_IN:0]      mismatch_cnt,
  output logic               first_mis_valid,
  output logic [N_IN-1:0]    first_mis_x
);

  localparam int unsigned     Depth      = 2 ** N_IN;
  localparam logic [N_IN-1:0] LastAddr   = {N_IN{1'b1}};
  localparam logic [3:0]      SettleLast = 4'(SETTLE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StCapture,
    StDump,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        settle_cnt_q, settle_cnt_d;
  logic [N_IN-1:0]   x_q, x_d;
  logic [N_IN-1:0]   rd_addr_q, rd_addr_d;
  logic [0:N_OUT-1]  rd_data_q, rd_data_d;
  logic [N_IN:0]     mis_cnt_q, mis_cnt_d;
  logic              first_valid_q, first_valid_d;
  logic [N_IN-1:0]   first_x_q, first_x_d;

  logic              table_we;
  logic              rd_load;
  logic              y_differ;
  logic [0:N_OUT-1]  table_mem [Depth];

  // Case inequality so an X on either response counts as a disagreement.
  assign y_differ = (dut_y_a !== dut_y_b);

  // Table storage: written once per vector in CAPTURE, never cleared.
  always_ff @(posedge clk) begin
    if (table_we) begin
      table_mem[x_q] <= dut_y_a;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      settle_cnt_q  <= '0;
      x_q           <= '0;
      rd_addr_q     <= '0;
      rd_data_q     <= '0;
      mis_cnt_q     <= '0;
      first_valid_q <= 1'b0;
      first_x_q     <= '0;
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      x_q           <= x_d;
      rd_addr_q     <= rd_addr_d;
      rd_data_q     <= rd_data_d;
      mis_cnt_q     <= mis_cnt_d;
      first_valid_q <= first_valid_d;
      first_x_q     <= first_x_d;
    end
  end

  // Next-state logic: sweep, capture, dump sequencing and read prefetch.
  always_comb begin
    state_d       = state_q;
    settle_cnt_d  = settle_cnt_q;
    x_d           = x_q;
    rd_addr_d     = rd_addr_q;
    rd_data_d     = rd_data_q;
    mis_cnt_d     = mis_cnt_q;
    first_valid_d = first_valid_q;
    first_x_d     = first_x_q;
    table_we      = 1'b0;
    rd_load       = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d       = StSettle;
          settle_cnt_d  = '0;
          x_d           = '0;
          mis_cnt_d     = '0;
          first_valid_d = 1'b0;
          first_x_d     = '0;
        end
      end

      StSettle: begin
        if (settle_cnt_q == SettleLast) begin
          state_d      = StCapture;
          settle_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end

      StCapture: begin
        table_we = 1'b1;
        if (y_differ) begin
          mis_cnt_d = mis_cnt_q + 1'b1;
          if (!first_valid_q) begin
            first_valid_d = 1'b1;
            first_x_d     = x_q;
          end
        end
        if (x_q == LastAddr) begin
          // dut_x holds the last vector until the next sweep starts.
          state_d   = StDump;
          rd_addr_d = '0;
          rd_load   = 1'b1;
        end else begin
          state_d = StSettle;
          x_d     = x_q + 1'b1;
        end
      end

      StDump: begin
        if (rd_ready) begin
          if (rd_addr_q == LastAddr) begin
            state_d = StDone;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
            rd_load   = 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Prefetch the entry to be presented next cycle; forward the write in
    // flight when it targets the same address.
    if (rd_load) begin
      rd_data_d = (table_we && (x_q == rd_addr_d)) ? dut_y_a : table_mem[rd_addr_d];
    end
  end

  // Output decode.
  always_comb begin
    busy     = (state_q == StSettle) || (state_q == StCapture) || (state_q == StDump);
    done     = (state_q == StDone);
    rd_valid = (state_q == StDump);
  end

  assign dut_x           = x_q;
  assign rd_addr         = rd_addr_q;
  assign rd_data         = rd_data_q;
  assign mismatch_cnt    = mis_cnt_q;
  assign first_mis_valid = first_valid_q;
  assign first_mis_x     = first_x_q;

endmodule

// File: tb/tb_truth_table_recorder.sv
// Bench for truth_table_recorder: three instances (SETTLE = 2, 1, 15) driven by
// table-based functions; expectations come from the function tables directly.
module tb_truth_table_recorder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  start, busy, done, rd_valid, rd_ready, first_mis_valid;
  logic [7:0]  dut_x [3];
  logic [7:0]  rd_addr [3];
  logic [0:4]  rd_data [3];
  logic [8:0]  mis_cnt [3];
  logic [7:0]  first_mis_x [3];

  // Function under test (A) and per-vector bit flips applied to B of instance 0.
  logic [0:4]  fa [256];
  logic [0:4]  flip [256];
  logic [0:4]  ya0, yb0, ya1, ya2;

  assign ya0 = fa[dut_x[0]];
  assign yb0 = fa[dut_x[0]] ^ flip[dut_x[0]];

  // Instances 1 and 2 see a one-stage registered implementation.
  always_ff @(posedge clk) begin
    ya1 <= fa[dut_x[1]];
    ya2 <= fa[dut_x[2]];
  end

  truth_table_recorder #(.N_IN(8), .N_OUT(5), .SETTLE(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .dut_x(dut_x[0]), .dut_y_a(ya0), .dut_y_b(yb0),
    .busy(busy[0]), .done(done[0]), .rd_valid(rd_valid[0]), .rd_ready(rd_ready[0]),
    .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .mismatch_cnt(mis_cnt[0]),
    .first_mis_valid(first_mis_valid[0]), .first_mis_x(first_mis_x[0])
  );

  truth_table_recorder #(.N_IN(8), .N_OUT(5), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .dut_x(dut_x[1]), .dut_y_a(ya1), .dut_y_b(ya1),
    .busy(busy[1]), .done(done[1]), .rd_valid(rd_valid[1]), .rd_ready(rd_ready[1]),
    .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .mismatch_cnt(mis_cnt[1]),
    .first_mis_valid(first_mis_valid[1]), .first_mis_x(first_mis_x[1])
  );

  truth_table_recorder #(.N_IN(8), .N_OUT(5), .SETTLE(15)) u_dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .dut_x(dut_x[2]), .dut_y_a(ya2), .dut_y_b(ya2),
    .busy(busy[2]), .done(done[2]), .rd_valid(rd_valid[2]), .rd_ready(rd_ready[2]),
    .rd_addr(rd_addr[2]), .rd_data(rd_data[2]), .mismatch_cnt(mis_cnt[2]),
    .first_mis_valid(first_mis_valid[2]), .first_mis_x(first_mis_x[2])
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset(input int k);
    check_eq("rst_dut_x", dut_x[k], 0);
    check_eq("rst_rd_addr", rd_addr[k], 0);
    check_eq("rst_rd_data", rd_data[k], 0);
    check_eq("rst_mis_cnt", mis_cnt[k], 0);
    check_eq("rst_first_x", first_mis_x[k], 0);
    check_eq("rst_busy", busy[k], 0);
    check_eq("rst_done", done[k], 0);
    check_eq("rst_rd_valid", rd_valid[k], 0);
    check_eq("rst_first_valid", first_mis_valid[k], 0);
  endtask

  // Mismatch summary straight from the flip table (only instance 0 has flips).
  task automatic model_mis(input int k, input int upto, output int cnt, output int first);
    cnt   = 0;
    first = -1;
    if (k == 0) begin
      for (int a = 0; a < upto; a++) begin
        if (flip[a] != 5'b0) begin
          cnt++;
          if (first < 0) first = a;
        end
      end
    end
  endtask

  // rmode: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
  // noise: pulse start once during SETTLE and once mid-dump.
  task automatic run_sweep(input int k, input int settle, input int rmode, input bit noise);
    int cyc, addr, ecnt, efirst;
    bit rdy;
    @(negedge clk);
    start[k]    = 1'b1;
    rd_ready[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    check_eq("busy_rise", busy[k], 1);
    check_eq("x_start", dut_x[k], 0);
    check_eq("cnt_clear", mis_cnt[k], 0);
    check_eq("first_clear", first_mis_valid[k], 0);

    cyc = 0;
    while (!rd_valid[k] && cyc < 5000) begin
      start[k] = (noise && cyc == 1);
      @(negedge clk);
      cyc++;
    end
    start[k] = 1'b0;
    check_eq("sweep_len", cyc, 256 * (settle + 1));
    if (cyc >= 5000) return;
    check_eq("x_hold_last", dut_x[k], 255);
    check_eq("busy_dump", busy[k], 1);

    addr = 0;
    cyc  = 0;
    while (addr < 256 && cyc < 4000) begin
      check_eq("rd_valid", rd_valid[k], 1);
      check_eq("rd_addr", rd_addr[k], addr);
      check_eq("rd_data", rd_data[k], fa[addr]);
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      rd_ready[k] = rdy;
      start[k]    = (noise && cyc == 5);
      @(negedge clk);
      cyc++;
      if (rdy) addr++;
    end
    start[k]    = 1'b0;
    rd_ready[k] = 1'b1;
    check_eq("handshakes", addr, 256);
    check_eq("rd_valid_drop", rd_valid[k], 0);
    check_eq("done", done[k], 1);
    check_eq("busy_off", busy[k], 0);

    model_mis(k, 256, ecnt, efirst);
    check_eq("mis_cnt", mis_cnt[k], ecnt);
    check_eq("first_valid", first_mis_valid[k], (ecnt > 0) ? 1 : 0);
    check_eq("first_x", first_mis_x[k], (efirst < 0) ? 0 : efirst);
  endtask

  initial begin
    int cyc, ecnt, efirst;
    rst      = 1'b1;
    start    = 3'b000;
    rd_ready = 3'b111;
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 5; j++) fa[i][j] = i[j];
      flip[i] = 5'b0;
    end
    #12;
    for (int k = 0; k < 3; k++) check_reset(k);
    @(negedge clk);
    rst = 1'b0;

    // y = x[4:0], both implementations agree.
    run_sweep(0, 2, 0, 1'b0);

    // B flips y0 at 0x2A and 0xF0 only.
    flip[8'h2A][0] = 1'b1;
    flip[8'hF0][0] = 1'b1;
    run_sweep(0, 2, 0, 1'b0);

    // Random function and random B flips under 1,0,0,1 backpressure.
    for (int i = 0; i < 256; i++) begin
      fa[i]   = 5'($urandom);
      flip[i] = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(1, 31)) : 5'b0;
    end
    run_sweep(0, 2, 1, 1'b0);

    // Starts in SETTLE and mid-dump are ignored; start from DONE clears counters.
    run_sweep(0, 2, 2, 1'b1);
    for (int i = 0; i < 256; i++) flip[i] = 5'b0;
    run_sweep(0, 2, 0, 1'b0);

    // Asynchronous reset mid-sweep at dut_x = 0x80.
    for (int i = 0; i < 256; i++) begin
      fa[i]   = 5'($urandom);
      flip[i] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'b0;
    end
    flip[8'h10] = 5'b00001;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    cyc = 0;
    while (dut_x[0] != 8'h80 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("reach_x80", dut_x[0], 8'h80);
    model_mis(0, 128, ecnt, efirst);
    check_eq("pre_rst_cnt", mis_cnt[0], ecnt);
    #2 rst = 1'b1;
    #1;
    check_reset(0);
    @(negedge clk);
    check_reset(0);
    rst = 1'b0;
    run_sweep(0, 2, 1, 1'b0);

    // Registered implementation A, SETTLE = 1 and SETTLE = 15.
    for (int i = 0; i < 256; i++) fa[i] = 5'($urandom);
    run_sweep(1, 1, 0, 1'b0);
    run_sweep(2, 15, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
